// File: rtl/count_seq_pkg.sv
// Shared types and default parameters for the count sequencer.
// Other files in this slice import this package.
package count_seq_pkg;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_GAP_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

endpackage

// File: rtl/seq_counter_core.sv
// Counter datapath for the sequencer.
// When several controls are high, clear wins over enable; with neither, the value holds.
module seq_counter_core
  import count_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Counter register: reset/clear to zero, otherwise step or hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/count_seq_ctrl.sv
// Run sequencer: IDLE -> LOAD -> RUN -> DONE (-> GAP -> LOAD in continuous mode).
// Owns the FSM, the start-time captures of limit/mode, and the saturating run counter.
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] limit,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [7:0]       run_cnt
);

  // Last value of the gap counter before leaving GAP.
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_limit;
  logic             r_mode;
  logic [3:0]       r_gap_cnt;
  logic [7:0]       r_run_cnt;
  logic [WIDTH-1:0] w_count;
  logic             w_clear;
  logic             w_enable;
  logic             w_at_limit;
  logic             w_accept;

  assign w_at_limit = (w_count == r_limit);
  assign w_accept   = (r_state == ST_IDLE) && start && !stop;

  // Next-state and datapath controls; stop overrides every transition.
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_enable     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_LOAD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RUN;
          w_clear      = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_next_state = ST_IDLE;
        end else if (w_at_limit) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_RUN;
          w_enable     = 1'b1;
        end
      end
      ST_DONE: begin
        if (stop) begin
          w_next_state = ST_IDLE;
        end else if (r_mode) begin
          w_next_state = (GAP_CYCLES == 0) ? ST_LOAD : ST_GAP;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (stop) begin
          w_next_state = ST_IDLE;
        end else if (r_gap_cnt == GAP_LAST) begin
          w_next_state = ST_LOAD;
        end else begin
          w_next_state = ST_GAP;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State, captured run parameters, gap timer and completed-run counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_limit   <= '0;
      r_mode    <= 1'b0;
      r_gap_cnt <= 4'd0;
      r_run_cnt <= 8'd0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_limit <= limit;
        r_mode  <= mode;
      end else begin
        r_limit <= r_limit;
        r_mode  <= r_mode;
      end
      if (r_state == ST_GAP) begin
        r_gap_cnt <= r_gap_cnt + 4'd1;
      end else begin
        r_gap_cnt <= 4'd0;
      end
      // A stopped DONE does not count as a completed run.
      if ((r_state == ST_DONE) && !stop && (r_run_cnt != 8'hFF)) begin
        r_run_cnt <= r_run_cnt + 8'd1;
      end else begin
        r_run_cnt <= r_run_cnt;
      end
    end
  end

  seq_counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_clear),
    .enable (w_enable),
    .count  (w_count)
  );

  assign count   = w_count;
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign run_cnt = r_run_cnt;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Scoreboard bench for count_seq_ctrl: stimulus queues per-cycle expectations and done times,
// a negedge monitor pops and compares them.
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic [3:0] limit;
  logic       mode;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic [7:0] run_cnt;

  int cyc    = 0;
  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    int         cyc;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic [7:0] rc;
  } exp_t;

  exp_t q[$];
  int   dq[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  count_seq_ctrl #(
    .WIDTH      (4),
    .GAP_CYCLES (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .limit   (limit),
    .mode    (mode),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .run_cnt (run_cnt)
  );

  function automatic void chk(string nm, int act, int req);
    n_tot = n_tot + 1;
    if (act == req) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s @cyc %0d: actual %0d, required %0d", nm, cyc, act, req);
    end
  endfunction

  function automatic void push(int c, int cnt, int b, int d, int rc);
    exp_t e;
    e.cyc   = c;
    e.count = 4'(cnt);
    e.busy  = 1'(b);
    e.done  = 1'(d);
    e.rc    = 8'(rc);
    q.push_back(e);
  endfunction

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compare queued snapshots and every done pulse against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      chk("count", int'(count), int'(e.count));
      chk("busy", int'(busy), int'(e.busy));
      chk("done", int'(done), int'(e.done));
      chk("run_cnt", int'(run_cnt), int'(e.rc));
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) chk("done_unexpected", 1, 0);
      else chk("done_cycle", cyc, dq.pop_front());
    end
  end

  initial begin
    int c;
    int b;
    reset = 1'b1; start = 1'b0; stop = 1'b0; limit = 4'd0; mode = 1'b0;
    push(2, 0, 0, 0, 0);
    wait_to(2);
    reset = 1'b0;

    // limit=3 one-shot; limit/mode changed after capture must not matter
    c = cyc; limit = 4'd3; mode = 1'b0; start = 1'b1;
    push(c + 1, 0, 1, 0, 0);
    for (int k = 0; k <= 3; k++) push(c + 2 + k, k, 1, 0, 0);
    push(c + 6, 3, 1, 1, 0);
    push(c + 7, 3, 0, 0, 1);
    dq.push_back(c + 6);
    wait_to(c + 1); start = 1'b0; limit = 4'd1; mode = 1'b1;
    wait_to(c + 8);

    // limit=0 one-shot: single RUN cycle
    c = cyc; limit = 4'd0; mode = 1'b0; start = 1'b1;
    push(c + 1, 3, 1, 0, 1);
    push(c + 2, 0, 1, 0, 1);
    push(c + 3, 0, 1, 1, 1);
    push(c + 4, 0, 0, 0, 2);
    dq.push_back(c + 3);
    wait_to(c + 1); start = 1'b0;
    wait_to(c + 5);

    // limit=2 continuous: period 7, stopped in GAP after third run
    c = cyc; limit = 4'd2; mode = 1'b1; start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      b = c + 7 * r;
      push(b + 1, (r == 0) ? 0 : 2, 1, 0, 2 + r);
      for (int k = 0; k <= 2; k++) push(b + 2 + k, k, 1, 0, 2 + r);
      push(b + 5, 2, 1, 1, 2 + r);
      dq.push_back(b + 5);
      push(b + 6, 2, 1, 0, 3 + r);
      push(b + 7, 2, (r < 2) ? 1 : 0, 0, 3 + r);
    end
    wait_to(c + 1); start = 1'b0;
    wait_to(c + 2); mode = 1'b0; limit = 4'd0;
    wait_to(c + 20); stop = 1'b1;
    wait_to(c + 21); stop = 1'b0;
    wait_to(c + 23);

    // limit=9, start pulse during RUN ignored, stop at count=5
    c = cyc; limit = 4'd9; mode = 1'b0; start = 1'b1;
    push(c + 1, 2, 1, 0, 5);
    for (int k = 0; k <= 5; k++) push(c + 2 + k, k, 1, 0, 5);
    push(c + 8, 5, 0, 0, 5);
    push(c + 9, 5, 0, 0, 5);
    wait_to(c + 1); start = 1'b0;
    wait_to(c + 4); start = 1'b1;
    wait_to(c + 5); start = 1'b0;
    wait_to(c + 7); stop = 1'b1;
    wait_to(c + 8); stop = 1'b0;
    wait_to(c + 10);

    // start together with stop in IDLE is ignored
    c = cyc; limit = 4'd4; start = 1'b1; stop = 1'b1;
    push(c + 1, 5, 0, 0, 5);
    push(c + 2, 5, 0, 0, 5);
    wait_to(c + 2); start = 1'b0; stop = 1'b0;
    wait_to(c + 3);

    // reset mid-run at count=7, start held during reset
    c = cyc; limit = 4'd12; mode = 1'b1; start = 1'b1;
    push(c + 1, 5, 1, 0, 5);
    for (int k = 0; k <= 7; k++) push(c + 2 + k, k, 1, 0, 5);
    push(c + 10, 0, 0, 0, 0);
    push(c + 11, 0, 0, 0, 0);
    push(c + 12, 0, 0, 0, 0);
    wait_to(c + 1); start = 1'b0;
    wait_to(c + 9); reset = 1'b1; start = 1'b1;
    wait_to(c + 11); reset = 1'b0; start = 1'b0;
    wait_to(c + 13);

    // limit=15: full range, no wrap
    c = cyc; limit = 4'd15; mode = 1'b0; start = 1'b1;
    push(c + 1, 0, 1, 0, 0);
    for (int k = 0; k <= 15; k++) push(c + 2 + k, k, 1, 0, 0);
    push(c + 18, 15, 1, 1, 0);
    push(c + 19, 15, 0, 0, 1);
    push(c + 20, 15, 0, 0, 1);
    dq.push_back(c + 18);
    wait_to(c + 1); start = 1'b0;
    wait_to(c + 22);

    chk("sb_drained", q.size(), 0);
    chk("done_drained", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter and limit width in bits.
REQ-002 Parameter GAP_CYCLES, default 2, SHALL set the idle cycles between runs in continuous mode; legal range 0..15.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-005 Port start, input, 1, SHALL be the run request, sampled only in IDLE.
REQ-006 Port stop, input, 1, SHALL be the abort request, sampled in every state.
REQ-007 Port limit, input, WIDTH, SHALL be the terminal count, captured at an accepted start.
REQ-008 Port mode, input, 1, SHALL select one-shot (0) or continuous (1), captured at an accepted start.
REQ-009 Port count, output, WIDTH, SHALL be the current counter value.
REQ-010 Port busy, output, 1, SHALL be high in every state except IDLE.
REQ-011 Port done, output, 1, SHALL be a one-cycle pulse per completed run.
REQ-012 Port run_cnt, output, 8, SHALL be the number of completed runs, saturating.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, RUN, DONE and GAP.
REQ-014 IDLE with start=1 and stop=0 SHALL capture limit and mode, then go to LOAD; count holds.
REQ-015 LOAD SHALL last one cycle, clear count to 0 and go to RUN.
REQ-016 RUN SHALL increment count by 1 per cycle while count != captured limit.
REQ-017 RUN with count == captured limit SHALL go to DONE with count held.
REQ-018 DONE SHALL last one cycle, drive done=1, increment run_cnt (saturate at 255), then go to GAP if captured mode=1, else IDLE.
REQ-019 GAP SHALL hold count for GAP_CYCLES cycles, then go to LOAD; with GAP_CYCLES=0, DONE SHALL go directly to LOAD.
REQ-020 Latency: from the edge sampling start, count=0 SHALL appear after edge 2, and done SHALL be high in the cycle after edge limit+3.
REQ-021 limit=0 SHALL give exactly one RUN cycle followed by DONE.
REQ-022 count SHALL never exceed the captured limit and SHALL never wrap past 2^WIDTH-1.
REQ-023 stop=1 in any non-IDLE state SHALL go to IDLE on the next edge: count holds, no done pulse, run_cnt unchanged.
REQ-024 stop SHALL take priority over start and over all FSM transitions, including DONE (that run's done is suppressed).
REQ-025 start outside IDLE SHALL be ignored and not queued.
REQ-026 Changes on limit or mode after capture SHALL have no effect until the next accepted start.
REQ-027 done and busy SHALL be decoded from registered state only, glitch-free, with no combinational path from inputs.

Reset
REQ-028 reset=1 SHALL force IDLE, count=0, run_cnt=0, done=0, busy=0, captured limit=0, captured mode=0 on the next edge.
REQ-029 reset SHALL take priority over stop and start, including mid-run and in GAP.

Structure
REQ-030 Package count_seq_pkg SHALL hold the state enum type and the default WIDTH and GAP_CYCLES constants.
REQ-031 The counter datapath (clear, enable, hold) SHALL be a sub-module named seq_counter_core; FSM, captures and run_cnt SHALL stay in count_seq_ctrl.

Verification
REQ-032 Scenario: reset 1 cycle, then start with limit=3, mode=0 -> count 0,1,2,3; done high for 1 cycle exactly 6 edges after start; busy low after; run_cnt=1.
REQ-033 Scenario: limit=0 one-shot -> one RUN cycle at count=0; done after edge 3; run_cnt increments by 1.
REQ-034 Scenario: limit=2, mode=1, GAP_CYCLES=2 -> done pulses every 7 cycles; busy stays high; run_cnt=3 after 3 runs.
REQ-035 Scenario: stop asserted while count=5 with limit=9 -> IDLE next edge, count holds 5, no done pulse, run_cnt unchanged.
REQ-036 Scenario: reset asserted mid-run at count=7 -> next edge count=0, run_cnt=0, busy=0; start ignored while reset=1.
REQ-037 Scenario: start pulsed during RUN, and start with stop together in IDLE -> both ignored; state and count unaffected.
